// File: rtl/display_pkg.sv
// Shared types and segment constants for the 7-segment display writer.
// Segment bit order is gfedcba, active-high, bit0 = a.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Nibble to 7-segment encoder with blanking and selectable polarity.
import display_pkg::*;

module hex_to_seg7 #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] raw;

    assign raw = blank ? SEG_OFF : hex2seg(nibble);
    assign seg = ACTIVE_LOW ? ~raw : raw;

endmodule

// File: rtl/avalon_display_writer.sv
// Avalon-MM master that pushes changed hex digits to a row of display PIOs.
import display_pkg::*;

module avalon_display_writer #(
    parameter int          NUM_DIGITS = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned STRIDE     = 16,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    value_valid,
    output logic                    value_ready,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank,
    output logic [31:0]             avm_address,
    output logic                    avm_write,
    output logic [31:0]             avm_writedata,
    output logic [3:0]              avm_byteenable,
    input  logic                    avm_waitrequest,
    output logic                    busy,
    output logic                    done_pulse
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    state_t                  state;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   blank_q;
    logic [6:0]              shadow [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   shadow_valid;

    logic [3:0] nibble;
    logic [6:0] seg;
    logic       changed;
    logic       advance;

    assign nibble = value_q[{idx, 2'b00} +: 4];

    hex_to_seg7 #(
        .ACTIVE_LOW(ACTIVE_LOW)
    ) u_enc (
        .nibble(nibble),
        .blank (blank_q[idx]),
        .seg   (seg)
    );

    // Everything on the bus derives from registers only, so a slave
    // stall cannot ripple back into address or data.
    assign changed = !shadow_valid[idx] || (shadow[idx] != seg);
    assign advance = !changed || !avm_waitrequest;

    assign avm_write      = (state == WRITE) && changed;
    assign avm_address    = BASE_ADDR + 32'(idx) * 32'(STRIDE);
    assign avm_writedata  = (state == WRITE) ? {25'b0, seg} : 32'b0;
    assign avm_byteenable = 4'b0001;

    assign value_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign done_pulse  = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            idx          <= '0;
            value_q      <= '0;
            blank_q      <= '0;
            shadow_valid <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (value_valid) begin
                        value_q <= value;
                        blank_q <= blank;
                        idx     <= '0;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (advance) begin
                        if (changed) begin
                            shadow[idx]       <= seg;
                            shadow_valid[idx] <= 1'b1;
                        end
                        if (idx == LAST) begin
                            idx   <= '0;
                            state <= DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_display_writer.sv
// Directed bench for avalon_display_writer with hand-computed bus traffic.
module tb_avalon_display_writer;

    logic        clk;
    logic        reset_n;
    logic        value_valid;
    logic        value_ready;
    logic [15:0] value;
    logic [3:0]  blank;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic        busy;
    logic        done_pulse;

    int n_cmp;
    int n_bad;
    int wcycles;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    avalon_display_writer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .value_valid    (value_valid),
        .value_ready    (value_ready),
        .value          (value),
        .blank          (blank),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_waitrequest(avm_waitrequest),
        .busy           (busy),
        .done_pulse     (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitor: accepted writes and cycles with a write request.
    always @(posedge clk) begin
        if (reset_n && avm_write) begin
            wcycles++;
            if (!avm_waitrequest) begin
                wa.push_back(avm_address);
                wd.push_back(avm_writedata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wcycles = 0;
    endtask

    // Handshake on the next edge; returns in the first cycle after it.
    task automatic start(input logic [15:0] v, input logic [3:0] b);
        value       = v;
        blank       = b;
        value_valid = 1'b1;
        @(posedge clk);
        #1;
        value_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done_pulse && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        value_valid     = 1'b0;
        value           = '0;
        blank           = '0;
        avm_waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (value_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", value_ready); end
        n_cmp++; if (avm_write !== 1'b0) begin n_bad++; $display("FAIL rst_write got %b want 0", avm_write); end
        n_cmp++; if (done_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done_pulse); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (avm_address !== 32'h1000) begin n_bad++; $display("FAIL rst_addr got %h want 00001000", avm_address); end
        n_cmp++; if (avm_writedata !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h want 0", avm_writedata); end
        n_cmp++; if (avm_byteenable !== 4'b0001) begin n_bad++; $display("FAIL rst_be got %b want 0001", avm_byteenable); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_update();
        logic [31:0] ea [4];
        logic [31:0] ed [4];
        ea = '{32'h1000, 32'h1010, 32'h1020, 32'h1030};
        ed = '{32'h19, 32'h30, 32'h24, 32'h79};
        clear_log();
        start(16'h1234, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (avm_write !== 1'b1) begin n_bad++; $display("FAIL first_wr%0d got %b want 1", i, avm_write); end
            n_cmp++; if (avm_address !== ea[i]) begin n_bad++; $display("FAIL first_addr%0d got %h want %h", i, avm_address, ea[i]); end
            n_cmp++; if (avm_writedata !== ed[i]) begin n_bad++; $display("FAIL first_data%0d got %h want %h", i, avm_writedata, ed[i]); end
            n_cmp++; if (value_ready !== 1'b0) begin n_bad++; $display("FAIL first_ready%0d got %b want 0", i, value_ready); end
            @(posedge clk);
            #1;
        end
        n_cmp++; if (done_pulse !== 1'b1) begin n_bad++; $display("FAIL first_done got %b want 1", done_pulse); end
        n_cmp++; if (avm_write !== 1'b0) begin n_bad++; $display("FAIL first_done_wr got %b want 0", avm_write); end
        n_cmp++; if (value_ready !== 1'b0) begin n_bad++; $display("FAIL first_done_ready got %b want 0", value_ready); end
        @(posedge clk);
        #1;
        n_cmp++; if (done_pulse !== 1'b0) begin n_bad++; $display("FAIL first_pulse_len got %b want 0", done_pulse); end
        n_cmp++; if (value_ready !== 1'b1) begin n_bad++; $display("FAIL first_idle_ready got %b want 1", value_ready); end
        n_cmp++; if (wa.size() !== 4) begin n_bad++; $display("FAIL first_count got %0d want 4", wa.size()); end
    endtask

    task automatic test_repeat();
        int cyc;
        clear_log();
        start(16'h1234, 4'b0000);
        wait_done(cyc);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL repeat_latency got %0d want 5", cyc); end
        n_cmp++; if (wcycles !== 0) begin n_bad++; $display("FAIL repeat_wcycles got %0d want 0", wcycles); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        int cyc;
        clear_log();
        avm_waitrequest = 1'b1;
        start(16'h1235, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (avm_write !== 1'b1) begin n_bad++; $display("FAIL stall_wr%0d got %b want 1", i, avm_write); end
            n_cmp++; if (avm_address !== 32'h1000) begin n_bad++; $display("FAIL stall_addr%0d got %h want 00001000", i, avm_address); end
            n_cmp++; if (avm_writedata !== 32'h12) begin n_bad++; $display("FAIL stall_data%0d got %h want 12", i, avm_writedata); end
            if (i == 3) avm_waitrequest = 1'b0;
            @(posedge clk);
            #1;
        end
        wait_done(cyc);
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL stall_latency got %0d want 4", cyc); end
        n_cmp++; if (wcycles !== 4) begin n_bad++; $display("FAIL stall_wcycles got %0d want 4", wcycles); end
        n_cmp++; if (wa.size() !== 1) begin n_bad++; $display("FAIL stall_count got %0d want 1", wa.size()); end
        if (wa.size() == 1) begin
            n_cmp++; if (wa[0] !== 32'h1000 || wd[0] !== 32'h12) begin n_bad++; $display("FAIL stall_write got %h/%h want 00001000/00000012", wa[0], wd[0]); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_blank();
        int cyc;
        clear_log();
        start(16'h1235, 4'b1000);
        wait_done(cyc);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL blank_latency got %0d want 5", cyc); end
        n_cmp++; if (wa.size() !== 1) begin n_bad++; $display("FAIL blank_count got %0d want 1", wa.size()); end
        if (wa.size() == 1) begin
            n_cmp++; if (wa[0] !== 32'h1030 || wd[0] !== 32'h7F) begin n_bad++; $display("FAIL blank_write got %h/%h want 00001030/0000007f", wa[0], wd[0]); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [31:0] ea [4];
        logic [31:0] ed [4];
        ea = '{32'h1000, 32'h1010, 32'h1020, 32'h1030};
        ed = '{32'h12, 32'h30, 32'h24, 32'h79};
        start(16'h5678, 4'b0000);
        @(posedge clk);
        #1;
        n_cmp++; if (avm_write !== 1'b1 || avm_address !== 32'h1010) begin n_bad++; $display("FAIL mid_second got %b/%h want 1/00001010", avm_write, avm_address); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (avm_write !== 1'b0) begin n_bad++; $display("FAIL mid_wr_drop got %b want 0", avm_write); end
        n_cmp++; if (value_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready got %b want 1", value_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        clear_log();
        start(16'h1235, 4'b0000);
        wait_done(cyc);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL mid_latency got %0d want 5", cyc); end
        n_cmp++; if (wa.size() !== 4) begin n_bad++; $display("FAIL mid_count got %0d want 4", wa.size()); end
        if (wa.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin n_bad++; $display("FAIL mid_write%0d got %h/%h want %h/%h", i, wa[i], wd[i], ea[i], ed[i]); end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_busy_ignore();
        int cyc;
        clear_log();
        start(16'h1234, 4'b0000);
        @(posedge clk);
        #1;
        n_cmp++; if (value_ready !== 1'b0) begin n_bad++; $display("FAIL busy_ready got %b want 0", value_ready); end
        value       = 16'hABCD;
        value_valid = 1'b1;
        @(posedge clk);
        #1;
        value_valid = 1'b0;
        wait_done(cyc);
        n_cmp++; if (done_pulse !== 1'b1) begin n_bad++; $display("FAIL busy_done got %b want 1", done_pulse); end
        n_cmp++; if (value_ready !== 1'b0) begin n_bad++; $display("FAIL busy_done_ready got %b want 0", value_ready); end
        @(posedge clk);
        #1;
        n_cmp++; if (value_ready !== 1'b1) begin n_bad++; $display("FAIL busy_idle_ready got %b want 1", value_ready); end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_stays_idle got %b want 0", busy); end
        n_cmp++; if (wa.size() !== 1) begin n_bad++; $display("FAIL busy_count got %0d want 1", wa.size()); end
        if (wa.size() == 1) begin
            n_cmp++; if (wa[0] !== 32'h1000 || wd[0] !== 32'h19) begin n_bad++; $display("FAIL busy_write got %h/%h want 00001000/00000019", wa[0], wd[0]); end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        wcycles = 0;
        test_reset();
        test_first_update();
        test_repeat();
        test_stall();
        test_blank();
        test_reset_mid();
        test_busy_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
